// File: rtl/pci_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : pci_arbiter_if
//  Purpose  : Bundle of PCI arbitration signals: per-master REQ#/GNT#, the
//             shared FRAME#/IRDY# sense lines and the arbiter status outputs.
//             The master modport is the arbiter side; slave is the bus side.
//  Revision : 1.0  initial release
// ============================================================================
interface pci_arbiter_if #(
    parameter int N_MASTERS = 2
);
    localparam int c_OWNER_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0] req_n;
    logic                 frame_n;
    logic                 irdy_n;
    logic [N_MASTERS-1:0] gnt_n;
    logic [c_OWNER_W-1:0] owner;
    logic                 bus_busy;

    modport master (
        input  req_n,
        input  frame_n,
        input  irdy_n,
        output gnt_n,
        output owner,
        output bus_busy
    );

    modport slave (
        output req_n,
        output frame_n,
        output irdy_n,
        input  gnt_n,
        input  owner,
        input  bus_busy
    );
endinterface
`default_nettype wire

// File: rtl/pci_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pci_arbiter
//  Purpose  : Round-robin PCI bus arbiter with grant timeout, one-cycle bus
//             turnaround and optional bus parking.
//             Optional feature macro: PCI_ARB_PARK_EN (compiles in the PARK
//             state; without it PARK_MASTER is only range-checked).
//  Revision : 1.0  initial release
// ============================================================================
module pci_arbiter #(
    parameter int N_MASTERS   = 2,
    parameter int GNT_TIMEOUT = 16,
    parameter int PARK_MASTER = 0
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    pci_arbiter_if.master   bus
);

    localparam int c_OWNER_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int c_CNT_W   = 8;

    localparam logic [c_CNT_W-1:0]   c_CNT_MAX   = '1;
    localparam logic [c_CNT_W-1:0]   c_TIMEOUT   = c_CNT_W'(GNT_TIMEOUT);
    localparam logic [N_MASTERS-1:0] c_ALL_HIGH  = '1;
    localparam logic [N_MASTERS-1:0] c_ONE       = {{(N_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [c_OWNER_W-1:0] c_RST_OWNER = c_OWNER_W'(N_MASTERS - 1);
`ifdef PCI_ARB_PARK_EN
    localparam logic [c_OWNER_W-1:0] c_PARK_IDX  = c_OWNER_W'(PARK_MASTER);
`endif

    localparam bit c_PARAMS_OK = (N_MASTERS >= 2) && (N_MASTERS <= 8) &&
                                 (GNT_TIMEOUT >= 1) && (GNT_TIMEOUT <= 255) &&
                                 (PARK_MASTER >= 0) && (PARK_MASTER < N_MASTERS);

    // Reject out-of-range configurations at elaboration time
    generate
        if (!c_PARAMS_OK) begin : g_paramError
            $error("pci_arbiter: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_BUSY  = 3'd2,
`ifdef PCI_ARB_PARK_EN
        ST_PARK  = 3'd4,
`endif
        ST_DEAD  = 3'd3
    } arbState_t;

    arbState_t              r_state;
    arbState_t              w_stateNext;
    logic [N_MASTERS-1:0]   r_gntN;
    logic [N_MASTERS-1:0]   w_gntNNext;
    logic [c_OWNER_W-1:0]   r_owner;
    logic [c_OWNER_W-1:0]   w_ownerNext;
    logic                   r_busBusy;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cntNext;
    logic [c_CNT_W-1:0]     w_cntInc;
    logic                   r_armed;
    logic                   w_busIdle;
    logic                   w_anyReq;
    logic [c_OWNER_W-1:0]   w_winner;

    // First requester strictly after 'last', wrapping; 'last' itself is tried last
    function automatic logic [c_OWNER_W-1:0] rrPick(
        input logic [N_MASTERS-1:0] reqN,
        input logic [c_OWNER_W-1:0] last
    );
        logic [c_OWNER_W-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = int'(last) + i;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end
            if (!found && !reqN[idx[c_OWNER_W-1:0]]) begin
                pick  = idx[c_OWNER_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Active-low grant vector with only bit 'idx' asserted
    function automatic logic [N_MASTERS-1:0] grantMask(input logic [c_OWNER_W-1:0] idx);
        return ~(c_ONE << idx);
    endfunction

    assign w_busIdle = bus.frame_n & bus.irdy_n;
    assign w_anyReq  = ~(&bus.req_n);
    assign w_winner  = rrPick(bus.req_n, r_owner);
    assign w_cntInc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Next-state and next-output decode; grants are registered from these
    always_comb begin
        w_stateNext = r_state;
        w_gntNNext  = r_gntN;
        w_ownerNext = r_owner;
        w_cntNext   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_gntNNext = c_ALL_HIGH;
                // r_armed holds off arbitration for the first edge after reset
                if (r_armed) begin
                    if (w_anyReq && w_busIdle) begin
                        w_stateNext = ST_GRANT;
                        w_ownerNext = w_winner;
                        w_gntNNext  = grantMask(w_winner);
                        w_cntNext   = '0;
                    end
`ifdef PCI_ARB_PARK_EN
                    else if (!w_anyReq) begin
                        w_stateNext = ST_PARK;
                        w_ownerNext = c_PARK_IDX;
                        w_gntNNext  = grantMask(c_PARK_IDX);
                    end
`endif
                end
            end
            ST_GRANT: begin
                // FRAME# wins over both request withdrawal and timeout
                if (!bus.frame_n) begin
                    w_stateNext = ST_BUSY;
                    w_gntNNext  = c_ALL_HIGH;
                end else if (bus.req_n[r_owner]) begin
                    w_stateNext = ST_DEAD;
                    w_gntNNext  = c_ALL_HIGH;
                end else begin
                    w_cntNext = w_cntInc;
                    if (w_cntInc >= c_TIMEOUT) begin
                        w_stateNext = ST_DEAD;
                        w_gntNNext  = c_ALL_HIGH;
                    end
                end
            end
            ST_BUSY: begin
                w_gntNNext = c_ALL_HIGH;
                if (w_busIdle) begin
                    w_stateNext = ST_DEAD;
                end
            end
            ST_DEAD: begin
                w_gntNNext  = c_ALL_HIGH;
                w_stateNext = ST_IDLE;
            end
`ifdef PCI_ARB_PARK_EN
            ST_PARK: begin
                // Parked master already holds GNT#, so its own request needs no turnaround
                if (!bus.frame_n) begin
                    w_stateNext = ST_BUSY;
                    w_gntNNext  = c_ALL_HIGH;
                end else if (!bus.req_n[c_PARK_IDX]) begin
                    w_stateNext = ST_GRANT;
                    w_cntNext   = '0;
                end else if (w_anyReq) begin
                    w_stateNext = ST_DEAD;
                    w_gntNNext  = c_ALL_HIGH;
                end
            end
`endif
            default: begin
                w_stateNext = ST_IDLE;
                w_gntNNext  = c_ALL_HIGH;
            end
        endcase
    end

    // State and output registers; reset releases all grants immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_gntN    <= c_ALL_HIGH;
            r_owner   <= c_RST_OWNER;
            r_busBusy <= 1'b0;
            r_cnt     <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_gntN    <= w_gntNNext;
            r_owner   <= w_ownerNext;
            r_busBusy <= (w_stateNext == ST_BUSY);
            r_cnt     <= w_cntNext;
            r_armed   <= 1'b1;
        end
    end

    assign bus.gnt_n    = r_gntN;
    assign bus.owner    = r_owner;
    assign bus.bus_busy = r_busBusy;

endmodule
`default_nettype wire

// File: tb/tb_pci_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pci_arbiter
//  Purpose  : Self-checking bench for pci_arbiter (N=4, timeout 4, park on 1):
//             vector table, directed corner sequences and a randomized run
//             against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pci_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;
    localparam int PM = 1;
`ifdef PCI_ARB_PARK_EN
    localparam bit PARK_EN = 1'b1;
`else
    localparam bit PARK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    pci_arbiter_if #(.N_MASTERS(N)) bus ();

    pci_arbiter #(
        .N_MASTERS   (N),
        .GNT_TIMEOUT (TO),
        .PARK_MASTER (PM)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [3:0] req;
        logic       frame;
        logic       irdy;
        logic [3:0] gnt;
        int         owner;
        logic       busy;
    } vec_t;

    vec_t tbl[14];

    // Reference model: who holds GNT#, whether the bus is in use or turning around
    int mHolder;
    bit mParked;
    bit mBusy;
    bit mDead;
    bit mArmed;
    int mOwner;
    int mAge;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chkOut(input string name, input logic [3:0] g, input int o, input logic b);
        chk({name, ".gnt_n"},    32'(bus.gnt_n),    32'(g));
        chk({name, ".owner"},    32'(bus.owner),    32'(o));
        chk({name, ".bus_busy"}, 32'(bus.bus_busy), 32'(b));
    endtask

    // Drive inputs (called just after a falling edge), take one rising edge, settle at falling edge
    task automatic step(input logic [3:0] r, input logic f, input logic i);
        bus.req_n   = r;
        bus.frame_n = f;
        bus.irdy_n  = i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n     = 1'b0;
        bus.req_n   = 4'hF;
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        repeat (2) @(negedge clk);
        chkOut("reset", 4'hF, 3, 1'b0);
        reset_n = 1'b1;
        mHolder = -1;
        mParked = 0;
        mBusy   = 0;
        mDead   = 0;
        mArmed  = 0;
        mOwner  = N - 1;
        mAge    = 0;
    endtask

    task automatic modelStep(input logic [3:0] r, input logic f, input logic i);
        bit idle;
        bit found;
        int idx;
        idle = f & i;
        if (!mArmed) begin
            mArmed = 1;
        end else if (mBusy) begin
            if (idle) begin
                mBusy = 0;
                mDead = 1;
            end
        end else if (mDead) begin
            mDead = 0;
        end else if (mHolder >= 0 && !mParked) begin
            if (!f) begin
                mHolder = -1;
                mBusy   = 1;
            end else if (r[mHolder]) begin
                mHolder = -1;
                mDead   = 1;
            end else begin
                mAge = (mAge < 255) ? mAge + 1 : 255;
                if (mAge >= TO) begin
                    mHolder = -1;
                    mDead   = 1;
                end
            end
        end else if (mParked) begin
            if (!f) begin
                mHolder = -1;
                mParked = 0;
                mBusy   = 1;
            end else if (!r[PM]) begin
                mParked = 0;
                mAge    = 0;
            end else if (r != 4'hF) begin
                mHolder = -1;
                mParked = 0;
                mDead   = 1;
            end
        end else begin
            if (r != 4'hF && idle) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    idx = (mOwner + k) % N;
                    if (!found && !r[idx]) begin
                        found   = 1;
                        mHolder = idx;
                    end
                end
                mOwner = mHolder;
                mAge   = 0;
            end else if (r == 4'hF && PARK_EN) begin
                mHolder = PM;
                mOwner  = PM;
                mParked = 1;
            end
        end
    endtask

    function automatic logic [3:0] modelGnt();
        logic [3:0] one;
        one = 4'b0001;
        return (mHolder >= 0) ? ~(one << mHolder) : 4'hF;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end within 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rq;
        logic       fr;
        logic       ir;

        reset_n     = 1'b0;
        bus.req_n   = 4'hF;
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;

        // Masters 0 and 3 requesting: grants 0,3,0, three busy cycles each, DEAD+IDLE between
        tbl[0]  = '{4'b0110, 1'b1, 1'b1, 4'b1111, 3, 1'b0};
        tbl[1]  = '{4'b0110, 1'b1, 1'b1, 4'b1110, 0, 1'b0};
        tbl[2]  = '{4'b0110, 1'b0, 1'b1, 4'b1111, 0, 1'b1};
        tbl[3]  = '{4'b0110, 1'b0, 1'b0, 4'b1111, 0, 1'b1};
        tbl[4]  = '{4'b0110, 1'b1, 1'b0, 4'b1111, 0, 1'b1};
        tbl[5]  = '{4'b0110, 1'b1, 1'b1, 4'b1111, 0, 1'b0};
        tbl[6]  = '{4'b0110, 1'b1, 1'b1, 4'b1111, 0, 1'b0};
        tbl[7]  = '{4'b0110, 1'b1, 1'b1, 4'b0111, 3, 1'b0};
        tbl[8]  = '{4'b0110, 1'b0, 1'b1, 4'b1111, 3, 1'b1};
        tbl[9]  = '{4'b0110, 1'b0, 1'b0, 4'b1111, 3, 1'b1};
        tbl[10] = '{4'b0110, 1'b1, 1'b0, 4'b1111, 3, 1'b1};
        tbl[11] = '{4'b0110, 1'b1, 1'b1, 4'b1111, 3, 1'b0};
        tbl[12] = '{4'b0110, 1'b1, 1'b1, 4'b1111, 3, 1'b0};
        tbl[13] = '{4'b0110, 1'b1, 1'b1, 4'b1110, 0, 1'b0};

        doReset();
        for (int v = 0; v < 14; v++) begin
            step(tbl[v].req, tbl[v].frame, tbl[v].irdy);
            chkOut($sformatf("vec%0d", v), tbl[v].gnt, tbl[v].owner, tbl[v].busy);
        end

        // Single request from master 0: no grant on first edge after reset, grant on second
        doReset();
        step(4'b1110, 1'b1, 1'b1);
        chkOut("firstEdge", 4'hF, 3, 1'b0);
        step(4'b1110, 1'b1, 1'b1);
        chkOut("grant0", 4'b1110, 0, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        chkOut("reqDrop", 4'hF, 0, 1'b0);

        // Grant timeout: master 2 granted, FRAME# never asserted
        doReset();
        step(4'b1011, 1'b1, 1'b1);
        step(4'b1011, 1'b1, 1'b1);
        chkOut("to.grant2", 4'b1011, 2, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            step(4'b1010, 1'b1, 1'b1);
            chkOut($sformatf("to.hold%0d", e), 4'b1011, 2, 1'b0);
        end
        step(4'b1010, 1'b1, 1'b1);
        chkOut("to.expire", 4'hF, 2, 1'b0);
        step(4'b1010, 1'b1, 1'b1);
        chkOut("to.idle", 4'hF, 2, 1'b0);
        step(4'b1010, 1'b1, 1'b1);
        chkOut("to.next", 4'b1110, 0, 1'b0);

        // FRAME# on the same edge the timeout would expire: straight to BUSY
        doReset();
        step(4'b1011, 1'b1, 1'b1);
        step(4'b1011, 1'b1, 1'b1);
        for (int e = 1; e <= 3; e++) begin
            step(4'b1011, 1'b1, 1'b1);
        end
        chkOut("race.pre", 4'b1011, 2, 1'b0);
        step(4'b1011, 1'b0, 1'b1);
        chkOut("race.busy", 4'hF, 2, 1'b1);
        step(4'b1011, 1'b0, 1'b0);
        chkOut("race.stay", 4'hF, 2, 1'b1);

        // Asynchronous reset during BUSY
        doReset();
        step(4'b1110, 1'b1, 1'b1);
        step(4'b1110, 1'b1, 1'b1);
        step(4'b1110, 1'b0, 1'b1);
        chkOut("ares.busy", 4'hF, 0, 1'b1);
        step(4'b1110, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chkOut("ares.async", 4'hF, 3, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef PCI_ARB_PARK_EN
        // Parking on master 1, then a foreign request forces a turnaround
        doReset();
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        chkOut("park", 4'b1101, 1, 1'b0);
        step(4'b0111, 1'b1, 1'b1);
        chkOut("park.dead", 4'hF, 1, 1'b0);
        step(4'b0111, 1'b1, 1'b1);
        chkOut("park.idle", 4'hF, 1, 1'b0);
        step(4'b0111, 1'b1, 1'b1);
        chkOut("park.grant3", 4'b0111, 3, 1'b0);
        // Parked master requesting keeps its grant and restarts the timeout
        doReset();
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1101, 1'b1, 1'b1);
        chkOut("park.own", 4'b1101, 1, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            step(4'b1101, 1'b1, 1'b1);
        end
        chkOut("park.ownHold", 4'b1101, 1, 1'b0);
        step(4'b1101, 1'b1, 1'b1);
        chkOut("park.ownTimeout", 4'hF, 1, 1'b0);
`else
        // Without parking, no request means no grant
        doReset();
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        chkOut("noPark", 4'hF, 3, 1'b0);
`endif

        // Randomized traffic against the reference model
        doReset();
        rq = 4'hF;
        fr = 1'b1;
        ir = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 4) == 0) begin
                    rq[b] = ~rq[b];
                end
            end
            fr = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 3) != 0);
            step(rq, fr, ir);
            modelStep(rq, fr, ir);
            chkOut("rand", modelGnt(), mOwner, mBusy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 The parameter list SHALL be: N_MASTERS, 2, number of bus masters (2..8).
REQ-002 The parameter list SHALL also include: GNT_TIMEOUT, 16, cycles a grant may stand without frame_n assertion (1..255).
REQ-003 The parameter list SHALL also include: PARK_MASTER, 0, index of parked master (0..N_MASTERS-1).
REQ-004 One clock; reset is asynchronous and active-low: ports clk and reset_n.
REQ-005 clk  input  1  bus clock, all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req_n  input  N_MASTERS  per-master bus request, active-low.
REQ-008 frame_n  input  1  shared PCI FRAME#, active-low.
REQ-009 irdy_n  input  1  shared PCI IRDY#, active-low.
REQ-010 gnt_n  output  N_MASTERS  per-master grant, active-low, registered.
REQ-011 owner  output  max(1,$clog2(N_MASTERS))  index of master holding or last holding the grant.
REQ-012 bus_busy  output  1  registered, high while in BUSY state.

Function
REQ-013 Bus idle SHALL be defined as frame_n=1 and irdy_n=1 sampled on the same edge.
REQ-014 The FSM SHALL have the states IDLE, PARK, GRANT, BUSY, DEAD.
REQ-015 At most one gnt_n bit SHALL be low in any cycle.
REQ-016 Winner selection SHALL be round-robin: the first requesting index after owner, searching upward with wrap to 0; owner itself is the lowest priority.
REQ-017 IDLE: if any req_n low and the bus is idle, the FSM SHALL go to GRANT and drive the winner's gnt_n low on that edge (1-cycle latency from req sample).
REQ-018 IDLE with no request SHALL go to PARK when PCI_ARB_PARK_EN is defined, else stay IDLE with all gnt_n high.
REQ-019 GRANT: frame_n sampled low SHALL cause a move to BUSY, with all gnt_n driven high and owner held.
REQ-020 GRANT: if the granted req_n deasserts before frame_n, the FSM SHALL go to DEAD.
REQ-021 GRANT: the timeout counter SHALL count edges in GRANT; on reaching GNT_TIMEOUT with frame_n still high, the FSM SHALL go to DEAD.
REQ-022 BUSY SHALL stay while the bus is not idle and go to DEAD on the first idle sample.
REQ-023 DEAD SHALL last exactly one cycle with all gnt_n high (bus turnaround), then go to IDLE.
REQ-024 PARK: gnt_n[PARK_MASTER] SHALL be held low and owner=PARK_MASTER.
REQ-025 PARK: frame_n low SHALL cause a move to BUSY.
REQ-026 PARK: if the parked master's req_n is low, the FSM SHALL go to GRANT without a DEAD cycle, gnt unchanged, and the counter cleared.
REQ-027 PARK: any other req_n low SHALL cause a move to DEAD.
REQ-028 Simultaneous frame_n low and timeout in GRANT: frame_n SHALL win (go to BUSY).
REQ-029 Requests arriving during BUSY or DEAD SHALL be held off until IDLE; no request memory beyond live req_n is required.
REQ-030 The timeout counter SHALL saturate, never wrap, and SHALL clear on every entry to GRANT.

Reset
REQ-031 While reset_n=0 the outputs SHALL be: gnt_n all 1, owner=N_MASTERS-1 (so master 0 wins first), bus_busy=0, state IDLE, counter 0.
REQ-032 An assertion of reset mid-transaction SHALL drop gnt_n immediately (asynchronously).
REQ-033 After reset_n deasserts, the first grant SHALL be no earlier than the second rising edge.

Configuration
REQ-034 Macro PCI_ARB_PARK_EN: when defined, the PARK state and parking behaviour SHALL be compiled in.
REQ-035 Without PCI_ARB_PARK_EN, the PARK state SHALL be absent, all gnt_n SHALL be high when no master requests, and PARK_MASTER SHALL be ignored.

Verification
REQ-036 The bench SHALL cover: N=4, req_n=4'b1110, bus idle -> gnt_n=4'b1110 one edge later, owner=0.
REQ-037 The bench SHALL cover: req_n=4'b0110 held across two transactions of 3 busy cycles each -> grants alternate 0,3,0 with exactly one DEAD cycle between them.
REQ-038 The bench SHALL cover: GNT_TIMEOUT=4, master 2 granted, frame_n held high -> gnt_n[2] rises after 4 edges, one dead cycle, next requester granted.
REQ-039 The bench SHALL cover: PCI_ARB_PARK_EN defined, PARK_MASTER=1, no requests -> gnt_n=4'b1101; then req_n[3] low -> one cycle all high, then gnt_n=4'b0111.
REQ-040 The bench SHALL cover: reset_n pulled low mid-BUSY -> gnt_n=4'b1111 and bus_busy=0 without waiting for a clock edge; owner=3.
REQ-041 The bench SHALL cover: frame_n low on the same edge as timeout expiry -> state BUSY, no DEAD cycle.
